// File: rtl/mtr_spd_ramp_if.sv
// Target/speed bundle between the motion planner and the speed ramp.
// Targets use a valid/ready handshake; speeds and at_tgt are continuously driven.
interface mtr_spd_ramp_if;
    logic               tgt_vld;
    logic signed [10:0] lft_tgt;
    logic signed [10:0] rght_tgt;
    logic               tgt_rdy;
    logic               estop;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               at_tgt;

    modport master (
        output tgt_vld, lft_tgt, rght_tgt, estop,
        input  tgt_rdy, lft_spd, rght_spd, at_tgt
    );

    modport slave (
        input  tgt_vld, lft_tgt, rght_tgt, estop,
        output tgt_rdy, lft_spd, rght_spd, at_tgt
    );
endinterface

// File: rtl/mtr_spd_ramp.sv
// Slew-limits two signed motor speeds toward their targets by STEP per tick, with a stop at zero on reversal.
// Targets load one edge after handshake; tgt_rdy is low only while in emergency stop.
module mtr_spd_ramp #(
    parameter int STEP     = 8,
    parameter int TICK_DIV = 1024
) (
    input  logic           clk,
    input  logic           rst,
    mtr_spd_ramp_if.slave  bus
);

    localparam int                 CW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      tick_cnt;
    logic               tick;
    logic               rdy;
    logic               hs;
    logic               at_tgt;
    logic signed [10:0] lft_tgt_q, rght_tgt_q, lft_tgt_nxt, rght_tgt_nxt;
    logic signed [10:0] lft_spd_q, rght_spd_q, lft_spd_nxt, rght_spd_nxt;
    logic signed [10:0] lft_clamp, rght_clamp;

    // -1024 has no positive mirror, so it is folded to -1023 to keep ramps symmetric
    function automatic logic signed [10:0] clamp_tgt(input logic signed [10:0] t);
        return (t == 11'sh400) ? 11'sh401 : t;
    endfunction

    function automatic logic signed [10:0] ramp_step(input logic signed [10:0] spd,
                                                     input logic signed [10:0] tgt);
        logic signed [11:0] spd_x;
        logic signed [11:0] diff;
        logic signed [11:0] mag;
        logic signed [11:0] nxt;
        spd_x = {spd[10], spd};
        diff  = {tgt[10], tgt} - spd_x;
        mag   = diff[11] ? -diff : diff;
        if (mag <= STEP_S)
            nxt = {tgt[10], tgt};
        else if (diff[11])
            nxt = spd_x - STEP_S;
        else
            nxt = spd_x + STEP_S;
        // a reversal always dwells one tick at zero before moving the other way
        if ((spd != 11'sd0) && (nxt != 12'sd0) && (nxt[11] != spd[10]))
            nxt = 12'sd0;
        return nxt[10:0];
    endfunction

    assign tick       = (tick_cnt == CW'(TICK_DIV - 1));
    assign rdy        = (state != ESTOP);
    assign hs         = bus.tgt_vld && rdy;
    assign at_tgt     = (lft_spd_q == lft_tgt_q) && (rght_spd_q == rght_tgt_q);
    assign lft_clamp  = clamp_tgt(bus.lft_tgt);
    assign rght_clamp = clamp_tgt(bus.rght_tgt);

    assign bus.tgt_rdy  = rdy;
    assign bus.lft_spd  = lft_spd_q;
    assign bus.rght_spd = rght_spd_q;
    assign bus.at_tgt   = at_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lft_tgt_q  <= '0;
            rght_tgt_q <= '0;
            lft_spd_q  <= '0;
            rght_spd_q <= '0;
        end else begin
            state      <= state_nxt;
            lft_tgt_q  <= lft_tgt_nxt;
            rght_tgt_q <= rght_tgt_nxt;
            lft_spd_q  <= lft_spd_nxt;
            rght_spd_q <= rght_spd_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lft_tgt_nxt  = lft_tgt_q;
        rght_tgt_nxt = rght_tgt_q;
        lft_spd_nxt  = lft_spd_q;
        rght_spd_nxt = rght_spd_q;
        if (bus.estop) begin
            state_nxt    = ESTOP;
            lft_tgt_nxt  = '0;
            rght_tgt_nxt = '0;
            lft_spd_nxt  = '0;
            rght_spd_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        lft_tgt_nxt  = lft_clamp;
                        rght_tgt_nxt = rght_clamp;
                        if ((lft_clamp != lft_spd_q) || (rght_clamp != rght_spd_q))
                            state_nxt = RAMP;
                    end
                end
                RAMP: begin
                    // the step on a tick uses the targets held before any same-edge handshake
                    if (tick) begin
                        lft_spd_nxt  = ramp_step(lft_spd_q, lft_tgt_q);
                        rght_spd_nxt = ramp_step(rght_spd_q, rght_tgt_q);
                    end
                    if (hs) begin
                        lft_tgt_nxt  = lft_clamp;
                        rght_tgt_nxt = rght_clamp;
                    end else if (at_tgt) begin
                        state_nxt = IDLE;
                    end
                end
                ESTOP:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtr_spd_ramp.sv
// Directed bench for mtr_spd_ramp with STEP=8, TICK_DIV=4; ticks land every fourth edge after reset release.
module tb_mtr_spd_ramp;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;

    mtr_spd_ramp_if sif();

    mtr_spd_ramp #(.STEP(8), .TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_spd(input string tag, input int l, input int r);
        chk({tag, ".lft"}, $signed(sif.lft_spd), l);
        chk({tag, ".rght"}, $signed(sif.rght_spd), r);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // advance to just after the next edge that carries a ramp tick
    task automatic to_tick();
        do cyc(); while (edges % 4 != 0);
    endtask

    task automatic offer(input int l, input int r);
        sif.tgt_vld  = 1'b1;
        sif.lft_tgt  = 11'(l);
        sif.rght_tgt = 11'(r);
        cyc();
        sif.tgt_vld  = 1'b0;
    endtask

    initial begin
        sif.tgt_vld  = 1'b0;
        sif.lft_tgt  = '0;
        sif.rght_tgt = '0;
        sif.estop    = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_spd("reset", 0, 0);
        chk("reset.rdy", sif.tgt_rdy, 1);
        chk("reset.at_tgt", sif.at_tgt, 1);
        rst = 1'b0;
        edges = 0;

        // basic symmetric ramp
        offer(20, -20);
        chk_spd("accept", 0, 0);
        chk("accept.at_tgt", sif.at_tgt, 0);
        to_tick(); chk_spd("ramp1", 8, -8);
        to_tick(); chk_spd("ramp2", 16, -16);
        to_tick(); chk_spd("ramp3", 20, -20);
        chk("ramp3.at_tgt", sif.at_tgt, 1);
        cyc();
        chk("idle.rdy", sif.tgt_rdy, 1);

        // right side crosses zero with a dwell while left settles in one tick
        offer(12, 12);
        to_tick(); chk_spd("xa1", 12, -12);
        to_tick(); chk_spd("xa2", 12, -4);
        to_tick(); chk_spd("xa3", 12, 0);
        to_tick(); chk_spd("xa4", 12, 8);
        to_tick(); chk_spd("xa5", 12, 12);
        chk("xa5.at_tgt", sif.at_tgt, 1);

        offer(-12, -12);
        to_tick(); chk_spd("xb1", 4, 4);
        to_tick(); chk_spd("xb2", 0, 0);
        chk("xb2.at_tgt", sif.at_tgt, 0);
        to_tick(); chk_spd("xb3", -8, -8);
        to_tick(); chk_spd("xb4", -12, -12);

        // estop wins over a simultaneous handshake
        sif.estop    = 1'b1;
        sif.tgt_vld  = 1'b1;
        sif.lft_tgt  = 11'sd100;
        sif.rght_tgt = 11'sd100;
        cyc();
        sif.tgt_vld = 1'b0;
        chk_spd("estop1", 0, 0);
        chk("estop1.rdy", sif.tgt_rdy, 0);
        chk("estop1.at_tgt", sif.at_tgt, 1);
        sif.estop = 1'b0;
        cyc();
        chk("estop1.release_rdy", sif.tgt_rdy, 1);
        to_tick(); chk_spd("estop1.dropped", 0, 0);

        // independent sides, mid-ramp retarget without overshoot
        offer(40, -5);
        to_tick(); chk_spd("rt1", 8, -5);
        to_tick(); chk_spd("rt2", 16, -5);
        chk("rt2.at_tgt", sif.at_tgt, 0);
        offer(24, -5);
        to_tick(); chk_spd("rt3", 24, -5);
        chk("rt3.at_tgt", sif.at_tgt, 1);
        to_tick(); chk_spd("rt4", 24, -5);

        // handshake on the tick edge: old target drives that step
        offer(40, -5);
        to_tick(); chk_spd("tk1", 32, -5);
        cyc(); cyc(); cyc();
        offer(0, -5);
        chk_spd("tk2", 40, -5);
        to_tick(); chk_spd("tk3", 32, -5);

        // estop at +32 mid-ramp
        sif.estop = 1'b1;
        cyc();
        chk_spd("estop2", 0, 0);
        chk("estop2.rdy", sif.tgt_rdy, 0);
        sif.estop = 1'b0;
        cyc();
        chk("estop2.release_rdy", sif.tgt_rdy, 1);
        chk_spd("estop2.release", 0, 0);

        // full-scale ramp, -1024 folds to -1023
        offer(-1024, 1023);
        for (int i = 0; i < 127; i++) to_tick();
        chk_spd("full127", -1016, 1016);
        to_tick(); chk_spd("full128", -1023, 1023);
        chk("full128.at_tgt", sif.at_tgt, 1);
        to_tick(); chk_spd("full129", -1023, 1023);

        // asynchronous reset mid-ramp
        offer(0, 0);
        to_tick(); chk_spd("pre_rst", -1015, 1015);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk_spd("async_rst", 0, 0);
        chk("async_rst.at_tgt", sif.at_tgt, 1);
        chk("async_rst.rdy", sif.tgt_rdy, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        edges = 0;
        to_tick(); chk_spd("post_rst", 0, 0);
        chk("post_rst.at_tgt", sif.at_tgt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtr_spd_ramp.md
MTR_SPD_RAMP -- requirements
Module: mtr_spd_ramp

Interface
REQ-001 SHALL have parameter STEP, default 8, max speed change per tick per side (1..1023).
REQ-002 SHALL have parameter TICK_DIV, default 1024, clocks per ramp tick (2..65536).
REQ-003 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tgt_vld  in  1  new target pair offered.
REQ-006 SHALL have port lft_tgt  in  11  signed left target speed.
REQ-007 SHALL have port rght_tgt  in  11  signed right target speed.
REQ-008 SHALL have port tgt_rdy  out  1  target accepted when tgt_vld&tgt_rdy.
REQ-009 SHALL have port estop  in  1  emergency stop, level-sensitive.
REQ-010 SHALL have port lft_spd  out  11  signed ramped left speed, feeds motor driver.
REQ-011 SHALL have port rght_spd  out  11  signed ramped right speed, feeds motor driver.
REQ-012 SHALL have port at_tgt  out  1  both outputs equal their held targets.

Function
REQ-013 SHALL hold registered targets lft_tgt_q/rght_tgt_q; lft_spd/rght_spd SHALL be registers, never combinational from inputs.
REQ-014 SHALL clamp accepted targets to [-1023,+1023]: input -1024 stored as -1023; outputs SHALL never equal -1024.
REQ-015 SHALL use a tick counter 0..TICK_DIV-1, free-running from reset, tick asserted the cycle count==TICK_DIV-1, then wrap to 0.
REQ-016 SHALL implement states IDLE, RAMP, ESTOP.
REQ-017 IDLE: tgt_rdy=1; on handshake, targets load next edge, state -> RAMP if new target differs from current output, else stay IDLE.
REQ-018 RAMP: tgt_rdy=1; handshake mid-ramp replaces targets next edge, ramp continues toward new targets from current outputs; tick counter not restarted.
REQ-019 On each tick in RAMP, per side: diff=tgt_q-spd in 12-bit signed; |diff|<=STEP -> spd=tgt_q; else spd+=sign(diff)*STEP.
REQ-020 Zero-crossing dwell: if spd nonzero and computed next value has opposite sign (or would skip zero), spd SHALL become 0 on that tick; movement resumes from 0 next tick.
REQ-021 RAMP -> IDLE on the cycle after both sides reach targets (at_tgt=1).
REQ-022 at_tgt SHALL be combinational (lft_spd==lft_tgt_q)&&(rght_spd==rght_tgt_q).
REQ-023 estop=1 in any state: next edge spd=0 both sides, tgt_q=0 both sides, state -> ESTOP; tgt_rdy=0 while in ESTOP; tgt_vld ignored.
REQ-024 ESTOP -> IDLE on first edge with estop=0; outputs remain 0 until a new target is accepted.
REQ-025 estop has priority over a simultaneous handshake; that target SHALL be dropped.
REQ-026 Handshake on the same edge as a tick: tick step uses old targets; new targets apply from next tick.
REQ-027 Sides ramp independently; one side reaching target SHALL not stop the other.

Reset
REQ-028 rst=1 SHALL asynchronously force lft_spd=0, rght_spd=0, targets=0, tick count=0, state=IDLE; thus tgt_rdy=1, at_tgt=1 during and after reset.
REQ-029 Reset asserted mid-ramp SHALL abandon ramp immediately, no partial step retained.

Verification (STEP=8, TICK_DIV=4)
REQ-030 Reset, then lft_tgt=+20, rght_tgt=-20 accepted -> lft 8,16,20 and rght -8,-16,-20 on successive ticks (4 clocks apart); at_tgt=1 after third tick; IDLE next cycle.
REQ-031 From spd=+12 both, target -12 both -> 4,0 (dwell),-8,-12 on successive ticks.
REQ-032 Mid-ramp (lft=+16 toward +40) retarget +24 -> next tick 24, at_tgt=1, no overshoot.
REQ-033 estop pulse during ramp at spd=+32 -> next edge spd=0, tgt_rdy=0; estop drop -> IDLE, spd stays 0, tgt_rdy=1.
REQ-034 Target -1024 accepted -> tgt_q=-1023, final spd=-1023; ramp at +1023 target never wraps.
REQ-035 rst asserted mid-cycle during RAMP -> outputs 0 immediately without waiting for clk edge.
